// File: rtl/regfile_rename_mp.sv
// ============================================================================
// regfile_rename_mp: renamed architectural register file, NISS issue / NCM commit
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_rename_mp #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ROB_W = 4,
  parameter int NISS  = 2,
  parameter int NCM   = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [NISS*AW-1:0]    iss_rs1_addr,
  input  logic [NISS*AW-1:0]    iss_rs2_addr,
  input  logic [NISS-1:0]       iss_rd_valid,
  input  logic [NISS*AW-1:0]    iss_rd_addr,
  input  logic [NISS*ROB_W-1:0] iss_rd_tag,
  output logic [NISS*XLEN-1:0]  rs1_data,
  output logic [NISS*XLEN-1:0]  rs2_data,
  output logic [NISS-1:0]       rs1_busy,
  output logic [NISS-1:0]       rs2_busy,
  output logic [NISS*ROB_W-1:0] rs1_tag,
  output logic [NISS*ROB_W-1:0] rs2_tag,
  input  logic [NCM-1:0]        cm_valid,
  input  logic [NCM*AW-1:0]     cm_addr,
  input  logic [NCM*XLEN-1:0]   cm_data,
  input  logic [NCM*ROB_W-1:0]  cm_tag,
  output logic [AW:0]           busy_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic             busy;
    logic [ROB_W-1:0] tag;
  } rd_t;

  logic [XLEN-1:0]  data_q [NREG];
  logic [XLEN-1:0]  data_d [NREG];
  logic [ROB_W-1:0] tag_q  [NREG];
  logic [ROB_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [NREG-1:0]  cm_match;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  // Register 0 is never a write/rename target, so its reset value of zero persists.
  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    busy_d   = busy_q;
    cm_match = '0;
    if (rdy) begin
      // Ascending slot order lets the younger commit overwrite data and the tag verdict.
      for (int j = 0; j < NCM; j++) begin
        if (cm_valid[j] && (cm_addr[j*AW +: AW] != '0)) begin
          data_d[cm_addr[j*AW +: AW]]   = cm_data[j*XLEN +: XLEN];
          cm_match[cm_addr[j*AW +: AW]] =
            (cm_tag[j*ROB_W +: ROB_W] == tag_q[cm_addr[j*AW +: AW]]);
        end
      end
      busy_d = busy_q & ~cm_match;
      if (flush) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < NISS; i++) begin
          if (iss_rd_valid[i] && (iss_rd_addr[i*AW +: AW] != '0)) begin
            busy_d[iss_rd_addr[i*AW +: AW]] = 1'b1;
            tag_d[iss_rd_addr[i*AW +: AW]]  = iss_rd_tag[i*ROB_W +: ROB_W];
          end
        end
      end
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_q[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Later checks override earlier ones, so evaluation runs lowest priority first.
  function automatic rd_t resolve(input int slot, input logic [AW-1:0] s);
    rd_t r;
    r.data = data_q[s];
    r.busy = busy_q[s];
    r.tag  = tag_q[s];
    if (rdy) begin
      for (int j = 0; j < NCM; j++) begin
        if (cm_valid[j] && (cm_addr[j*AW +: AW] == s)) begin
          r.data = cm_data[j*XLEN +: XLEN];
          r.busy = (cm_tag[j*ROB_W +: ROB_W] == tag_q[s]) ? 1'b0 : busy_q[s];
        end
      end
    end
    for (int k = 0; k < NISS; k++) begin
      if ((k < slot) && iss_rd_valid[k] && (iss_rd_addr[k*AW +: AW] == s)) begin
        r.busy = 1'b1;
        r.tag  = iss_rd_tag[k*ROB_W +: ROB_W];
      end
    end
    if (s == '0) begin
      r = '0;
    end
    return r;
  endfunction

  for (genvar i = 0; i < NISS; i++) begin : g_slot
    rd_t src1, src2;

    always_comb begin
      src1 = resolve(i, iss_rs1_addr[i*AW +: AW]);
      src2 = resolve(i, iss_rs2_addr[i*AW +: AW]);
    end

    assign rs1_data[i*XLEN +: XLEN]   = src1.data;
    assign rs1_busy[i]                = src1.busy;
    assign rs1_tag[i*ROB_W +: ROB_W]  = src1.tag;
    assign rs2_data[i*XLEN +: XLEN]   = src2.data;
    assign rs2_busy[i]                = src2.busy;
    assign rs2_tag[i*ROB_W +: ROB_W]  = src2.tag;
  end

endmodule

`default_nettype wire

// File: doc/regfile_rename_mp.md
REGFILE_RENAME_MP -- requirements
Module: regfile_rename_mp

Interface
REQ-001 SHALL have parameters: XLEN, default 32, data width; NREG, default 32, architectural register count (power of 2); ROB_W, default 4, ROB tag width; NISS, default 2, rename/issue slots per cycle; NCM, default 2, commit slots per cycle; AW = clog2(NREG).
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; state holds when low
- flush  in  1  misbranch recovery
- iss_rs1_addr, iss_rs2_addr  in  NISS*AW  source register addresses, slot i at bits [i*AW +: AW]
- iss_rd_valid  in  NISS  slot i allocates a destination
- iss_rd_addr  in  NISS*AW  destination register addresses
- iss_rd_tag  in  NISS*ROB_W  ROB tag of each allocating instruction
- rs1_data, rs2_data  out  NISS*XLEN  source values
- rs1_busy, rs2_busy  out  NISS  source still pending in ROB
- rs1_tag, rs2_tag  out  NISS*ROB_W  ROB tag producing the source
- cm_valid  in  NCM  commit slot j valid
- cm_addr  in  NCM*AW  commit destination register
- cm_data  in  NCM*XLEN  commit value
- cm_tag  in  NCM*ROB_W  committing ROB tag
- busy_cnt  out  AW+1  registered count of busy registers

Function
REQ-003 SHALL hold per register: data (XLEN), tag (ROB_W), busy (1); register 0 SHALL always read data 0, busy 0, tag 0 and SHALL never be written, renamed or counted.
REQ-004 SHALL, on a clock edge with rdy=1 and flush=0, for each valid commit slot with cm_addr!=0, write cm_data to data[cm_addr].
REQ-005 SHALL clear busy[cm_addr] on commit only when cm_tag equals the stored tag and no issue slot renames the same register in that cycle.
REQ-006 SHALL, when two commit slots target the same register in one cycle, let the higher-index (younger) slot's data and tag comparison win.
REQ-007 SHALL, for each issue slot with iss_rd_valid=1 and iss_rd_addr!=0, set busy=1 and tag=iss_rd_tag at the clock edge; the higher-index slot wins when slots share rd.
REQ-008 SHALL give rename priority over commit busy-clear for the same register in the same cycle.
REQ-009 SHALL produce read outputs combinationally (zero latency); per slot i and source s, apply priority:
- (a) s==0 -> data 0, busy 0, tag 0;
- (b) nearest lower-index slot k<i with iss_rd_valid and rd==s -> busy 1, tag=iss_rd_tag[k], data don't-care;
- (c) commit bypass: youngest valid commit slot with cm_addr==s supplies data; busy=0 if its cm_tag equals the stored tag, else stored busy; tag = stored tag;
- (d) stored data/busy/tag.
REQ-010 SHALL apply REQ-009 bypass (c) only when rdy=1; rule (b) applies regardless of rdy.
REQ-011 SHALL, on a clock edge with rdy=1 and flush=1, clear every busy bit, still perform commit data writes (REQ-004), and drop all renames; tags unchanged.
REQ-012 SHALL hold all state when rdy=0 (flush and rst excepted: flush acts only with rdy=1; rst acts regardless).
REQ-013 SHALL update busy_cnt one cycle after the busy array changes, equal to the popcount of busy[1..NREG-1].

Reset
REQ-014 SHALL, when rst=1 at a clock edge, set all data to 0, all tags to 0, all busy to 0 and busy_cnt to 0, overriding flush, commit and rename.
REQ-015 SHALL present read outputs data 0, busy 0 in the cycle after reset for every address.

Verification
REQ-016 Rename/commit: slot0 renames x5 tag 3; next cycle commit x5 tag 3 data 0xAA -> same-cycle read x5 gives 0xAA busy 0; after edge busy[5]=0, busy_cnt 1 -> 0.
REQ-017 Stale commit: rename x5 tag 3, rename x5 tag 7, commit x5 tag 3 data 0x11 -> data[5]=0x11, busy[5]=1, tag[5]=7.
REQ-018 Intra-group: slot0 renames x8 tag 2, slot1 reads rs1=x8 same cycle -> slot1 rs1_busy=1, rs1_tag=2; both slots rename x9 (tags 4, 5) -> tag[9]=5.
REQ-019 Simultaneous: commit x6 tag 1 and rename x6 tag 9 same edge -> busy[6]=1, tag[6]=9, data[6]=committed value; dual commit to x4 with data 0x1/0x2 -> data[4]=0x2.
REQ-020 Flush: 6 regs busy, flush with commit x3 data 0x33 and rename x10 -> all busy 0, data[3]=0x33, x10 not busy, busy_cnt 0 next cycle.
REQ-021 x0/rdy/reset: commit x0 data 0xFF and rename x0 -> reads 0, not busy; rdy=0 with commit -> no change; rst mid-sequence -> all outputs 0 next cycle.
